// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, picks the next fetch address by redirect priority,
// and holds a redirect back while an instruction-memory request is still outstanding.
module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        Exception,
   input  logic        ImemReady,
   output logic [31:0] PCOut,
   output logic [31:0] PCPlus4,
   output logic        FetchReq,
   output logic        FetchValid,
   output logic        Flush,
   output logic        MisalignErr
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pend_target;
   logic [1:0]  pend_src;
   logic        flush_q;
   logic        misalign_q;

   logic [1:0]  new_src;
   logic [31:0] new_target;
   logic        new_misalign;
   logic        take_new;
   logic        fetch_req;

   // Priority select of this cycle's redirect; source code 3=exception, 2=jump, 1=branch, 0=none.
   always_comb begin
      new_src      = 2'd0;
      new_target   = EXC_VECTOR;
      new_misalign = 1'b0;
      if (Exception) begin
         new_src    = 2'd3;
         new_target = EXC_VECTOR;
      end else if (Jump) begin
         new_src = 2'd2;
         if (JumpTarget[1:0] != 2'b00) begin
            new_target   = EXC_VECTOR;
            new_misalign = 1'b1;
         end else begin
            new_target = JumpTarget;
         end
      end else if (BranchTaken) begin
         new_src = 2'd1;
         if (BranchTarget[1:0] != 2'b00) begin
            new_target   = EXC_VECTOR;
            new_misalign = 1'b1;
         end else begin
            new_target = BranchTarget;
         end
      end else begin
         new_src = 2'd0;
      end
   end

   // Request generation and whether a new redirect wins over what is already pending.
   always_comb begin
      fetch_req = 1'b0;
      take_new  = 1'b0;
      case (state)
         RUN: begin
            fetch_req = ~Stall;
            take_new  = (new_src != 2'd0);
         end
         PEND: begin
            fetch_req = 1'b1;
            take_new  = (new_src != 2'd0) && (new_src >= pend_src);
         end
         default: begin
            fetch_req = 1'b0;
            take_new  = 1'b0;
         end
      endcase
   end

   // Sequencer state, PC and the one-cycle Flush/MisalignErr pulses.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state       <= BOOT;
         pc          <= RESET_VECTOR;
         pend_target <= 32'h0000_0000;
         pend_src    <= 2'd0;
         flush_q     <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
         case (state)
            BOOT: begin
               state <= RUN;
            end
            RUN: begin
               if (take_new) begin
                  misalign_q <= new_misalign;
                  // The address must stay stable until an issued request is accepted.
                  if (!fetch_req || ImemReady) begin
                     pc      <= new_target;
                     flush_q <= 1'b1;
                  end else begin
                     pend_target <= new_target;
                     pend_src    <= new_src;
                     state       <= PEND;
                  end
               end else if (fetch_req && ImemReady) begin
                  pc <= pc + 32'd4;
               end else begin
                  pc <= pc;
               end
            end
            PEND: begin
               if (take_new) begin
                  misalign_q <= new_misalign;
               end
               if (ImemReady) begin
                  pc       <= take_new ? new_target : pend_target;
                  flush_q  <= 1'b1;
                  pend_src <= 2'd0;
                  state    <= RUN;
               end else if (take_new) begin
                  pend_target <= new_target;
                  pend_src    <= new_src;
               end else begin
                  pend_target <= pend_target;
               end
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

   assign PCOut       = pc;
   assign PCPlus4     = pc + 32'd4;
   assign FetchReq    = fetch_req;
   assign FetchValid  = fetch_req & ImemReady;
   assign Flush       = flush_q;
   assign MisalignErr = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed literal checks followed by random
// stimulus compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

   localparam logic [31:0] EXC = 32'h0000_0080;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        Stall = 1'b0;
   logic        BranchTaken = 1'b0;
   logic [31:0] BranchTarget = 32'h0;
   logic        Jump = 1'b0;
   logic [31:0] JumpTarget = 32'h0;
   logic        Exception = 1'b0;
   logic        ImemReady = 1'b1;
   logic [31:0] PCOut;
   logic [31:0] PCPlus4;
   logic        FetchReq;
   logic        FetchValid;
   logic        Flush;
   logic        MisalignErr;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // model state
   logic [31:0] m_pc = 32'h0;
   bit          m_boot = 1'b1;
   bit          m_has_pend = 1'b0;
   logic [31:0] m_ptgt = 32'h0;
   int          m_pprio = 0;
   bit          m_flush = 1'b0;
   bit          m_mis = 1'b0;

   fetch_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
      .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
      .Exception(Exception), .ImemReady(ImemReady), .PCOut(PCOut), .PCPlus4(PCPlus4),
      .FetchReq(FetchReq), .FetchValid(FetchValid), .Flush(Flush), .MisalignErr(MisalignErr)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: redirect priority exc>jump>branch, misaligned -> EXC vector,
   // a redirect waits while an issued request is unaccepted, same-or-higher priority overwrites.
   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         m_pc = 32'h0; m_boot = 1'b1; m_has_pend = 1'b0; m_pprio = 0;
         m_flush = 1'b0; m_mis = 1'b0;
      end else begin
         int prio;
         logic [31:0] raw, tgt;
         bit bad, req, nf, nm;
         prio = Exception ? 3 : Jump ? 2 : BranchTaken ? 1 : 0;
         raw  = Exception ? EXC : Jump ? JumpTarget : BranchTarget;
         bad  = (prio == 1 || prio == 2) && (raw % 4 != 0);
         tgt  = bad ? EXC : raw;
         req  = !m_boot && (m_has_pend || !Stall);
         nf = 1'b0; nm = 1'b0;
         if (m_boot) begin
            m_boot = 1'b0;
         end else if (m_has_pend) begin
            if (prio != 0 && prio >= m_pprio) begin
               nm = bad; m_ptgt = tgt; m_pprio = prio;
            end
            if (ImemReady) begin
               m_pc = m_ptgt; nf = 1'b1; m_has_pend = 1'b0; m_pprio = 0;
            end
         end else if (prio != 0) begin
            nm = bad;
            if (!req || ImemReady) begin
               m_pc = tgt; nf = 1'b1;
            end else begin
               m_has_pend = 1'b1; m_ptgt = tgt; m_pprio = prio;
            end
         end else if (req && ImemReady) begin
            m_pc = m_pc + 32'd4;
         end
         m_flush = nf; m_mis = nm;
      end
   end

   // Compare DUT against the model away from the active edge.
   always @(negedge Clk) begin
      if (chk_en) begin
         bit ereq;
         ereq = !m_boot && (m_has_pend || !Stall);
         chk("PCOut", PCOut, m_pc);
         chk("PCPlus4", PCPlus4, m_pc + 32'd4);
         chk("FetchReq", {31'd0, FetchReq}, {31'd0, ereq});
         chk("FetchValid", {31'd0, FetchValid}, {31'd0, ereq & ImemReady});
         chk("Flush", {31'd0, Flush}, {31'd0, m_flush});
         chk("MisalignErr", {31'd0, MisalignErr}, {31'd0, m_mis});
      end
   end

   task automatic cyc();
      @(posedge Clk);
      #2;
   endtask

   task automatic clr();
      Jump = 1'b0; BranchTaken = 1'b0; Exception = 1'b0; Stall = 1'b0; ImemReady = 1'b1;
   endtask

   initial begin
      #1 chk_en = 1'b1;
      cyc(); cyc();
      chk("rst_pc", PCOut, 32'h0);
      chk("rst_req", {31'd0, FetchReq}, 32'd0);
      Reset = 1'b1;
      #1 chk("boot_req", {31'd0, FetchReq}, 32'd0);
      cyc(); chk("run_pc0", PCOut, 32'h0); chk("run_req", {31'd0, FetchReq}, 32'd1);
      cyc(); chk("seq_4", PCOut, 32'h4);
      cyc(); chk("seq_8", PCOut, 32'h8);
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(); chk("stall_pc", PCOut, 32'h8); chk("stall_req", {31'd0, FetchReq}, 32'd0);
      end
      Stall = 1'b0;
      #1 chk("unstall_req", {31'd0, FetchReq}, 32'd1);
      cyc(); chk("seq_c", PCOut, 32'hC); chk("seq_noflush", {31'd0, Flush}, 32'd0);
      cyc(); chk("seq_10", PCOut, 32'h10);
      BranchTaken = 1'b1; BranchTarget = 32'h40;
      cyc(); clr(); chk("br_pc", PCOut, 32'h40); chk("br_flush", {31'd0, Flush}, 32'd1);
      cyc(); chk("br_next", PCOut, 32'h44); chk("br_flush_end", {31'd0, Flush}, 32'd0);
      Jump = 1'b1; JumpTarget = 32'h20;
      cyc(); clr(); chk("j20", PCOut, 32'h20);
      Jump = 1'b1; JumpTarget = 32'h100; ImemReady = 1'b0;
      cyc(); chk("pend_hold1", PCOut, 32'h20); chk("pend_req", {31'd0, FetchReq}, 32'd1);
      Jump = 1'b0; Exception = 1'b1;
      cyc(); chk("pend_hold2", PCOut, 32'h20);
      clr();
      cyc(); chk("pend_exc", PCOut, 32'h80); chk("pend_flush", {31'd0, Flush}, 32'd1);
      BranchTaken = 1'b1; BranchTarget = 32'h42;
      cyc(); clr(); chk("mis_pc", PCOut, 32'h80); chk("mis_err", {31'd0, MisalignErr}, 32'd1);
      chk("mis_flush", {31'd0, Flush}, 32'd1);
      cyc(); chk("mis_end", {31'd0, MisalignErr}, 32'd0); chk("mis_next", PCOut, 32'h84);
      Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
      cyc(); clr(); chk("wrap_p4", PCPlus4, 32'h0);
      cyc(); chk("wrap_pc", PCOut, 32'h0);
      cyc(); chk("wrap_4", PCOut, 32'h4);
      Jump = 1'b1; JumpTarget = 32'h200; ImemReady = 1'b0;
      cyc(); clr(); chk("rp_hold", PCOut, 32'h4);
      Reset = 1'b0;
      #1 chk("rp_pc", PCOut, 32'h0); chk("rp_req", {31'd0, FetchReq}, 32'd0);
      chk("rp_flush", {31'd0, Flush}, 32'd0);
      cyc(); Reset = 1'b1;
      cyc(); cyc(); chk("rp_discard", PCOut, 32'h4); chk("rp_noflush", {31'd0, Flush}, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            Reset = 1'b0;
            cyc();
            Reset = 1'b1;
         end
         Stall       = ($urandom_range(0, 3) == 0);
         Exception   = ($urandom_range(0, 19) == 0);
         Jump        = ($urandom_range(0, 9) == 0);
         BranchTaken = ($urandom_range(0, 6) == 0);
         ImemReady   = ($urandom_range(0, 9) < 6);
         JumpTarget  = $urandom;
         BranchTarget = $urandom;
         if ($urandom_range(0, 3) != 0) JumpTarget[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) BranchTarget[1:0] = 2'b00;
         if ($urandom_range(0, 7) == 0) JumpTarget = 32'hFFFF_FFF0;
         cyc();
      end
      clr();
      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction-fetch stage: owns the program counter, chooses the next fetch address, and runs the request/ready handshake with instruction memory.
- Redirect sources, in priority order: exception vector, jump target, branch target, sequential PC+4.
- Handles pipeline stalls and redirects that arrive while a fetch is outstanding.
- Sits between the hazard/branch logic in ID/EX and the instruction memory; feeds the IF/ID register.

Parameters:
- RESET_VECTOR, 32'h00000000, PC loaded on reset.
- EXC_VECTOR, 32'h00000080, PC loaded on exception or misaligned redirect.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (asserted when 0).
- Stall  in  1  hazard unit: do not issue a new fetch.
- BranchTaken  in  1  branch resolved taken this cycle.
- BranchTarget  in  32  branch target address.
- Jump  in  1  jump (J/JAL/JR) this cycle.
- JumpTarget  in  32  jump target address.
- Exception  in  1  take exception this cycle.
- ImemReady  in  1  instruction memory accepts the request this cycle.
- PCOut  out  32  current fetch address (registered).
- PCPlus4  out  32  PCOut + 4, combinational, mod 2^32.
- FetchReq  out  1  fetch request to instruction memory.
- FetchValid  out  1  FetchReq & ImemReady: the instruction at PCOut is delivered this cycle.
- Flush  out  1  registered one-cycle pulse that invalidates the IF/ID entry.
- MisalignErr  out  1  registered one-cycle pulse: redirect target had [1:0] != 0.

Behaviour:
- Reset (Reset=0, asynchronous):
  - PCOut=RESET_VECTOR; Flush=0, MisalignErr=0, FetchReq=0.
  - State=BOOT; pending register cleared.
- States: BOOT, RUN, PEND.
  - BOOT: FetchReq=0 for exactly one cycle after reset release, then go to RUN. Redirect inputs are ignored in BOOT.
  - RUN: FetchReq = !Stall.
  - PEND: a redirect is waiting for the outstanding request to be accepted. FetchReq=1.
- Redirect selection:
  - Priority: Exception > Jump > BranchTaken.
  - Selected target T = EXC_VECTOR, JumpTarget or BranchTarget respectively.
  - Jump/branch target with T[1:0] != 0: use EXC_VECTOR instead and pulse MisalignErr next cycle.
- RUN, no redirect:
  - FetchValid=1: PCOut <= PCOut+4 at the next edge.
  - Otherwise PCOut holds.
- RUN, redirect, and (FetchReq=0 or ImemReady=1):
  - PCOut <= T at the next edge.
  - Flush=1 in the next cycle.
  - Stay in RUN.
- RUN, redirect, FetchReq=1, ImemReady=0:
  - PCOut holds; address must stay stable until accepted.
  - Latch T into the pending register; go to PEND.
- PEND:
  - Another redirect arrives: it overwrites the pending target if its priority is >= the pending one. Track a 2-bit pending source code.
  - ImemReady=1: PCOut <= pending target; Flush=1 next cycle so the just-accepted instruction is killed; return to RUN.
  - Stall is ignored in PEND; the outstanding request completes.
- Stall:
  - Gates only new requests in RUN. PCOut holds; Flush is not asserted.
  - Redirect during Stall takes effect immediately (FetchReq=0 case).
- Wrap-around: PC 32'hFFFFFFFC + 4 = 32'h00000000, no error.
- Flush and MisalignErr are single-cycle pulses, even when redirects arrive back to back; each redirect yields its own pulse.
- Reset mid-PEND: pending target is discarded and the block returns to BOOT.

Test Plan:
- Reset=0 then 1, ImemReady=1 always -> FetchReq low 1 cycle; PCOut sequence 0x0, 0x4, 0x8, 0xC; Flush=0.
- At PC=0x10 with ImemReady=1, BranchTaken=1, BranchTarget=0x40 -> next PCOut=0x40, Flush=1 for one cycle, then 0x44.
- ImemReady=0 at PC=0x20 with Jump=1, JumpTarget=0x100, then Exception=1 the next cycle, ImemReady=1 on the third cycle -> PCOut stays 0x20 while waiting, then becomes 0x80 (EXC_VECTOR) with Flush=1.
- Stall=1 for 3 cycles at PC=0x8 -> FetchReq=0, PCOut=0x8 held; release -> 0x8 fetched, then 0xC.
- BranchTarget=0x42 taken -> PCOut=0x80, MisalignErr=1 for one cycle, Flush=1.
- PC=0xFFFFFFFC, FetchValid -> PCOut=0x0; Reset pulse while in PEND -> PCOut=0x0, FetchReq=0, no Flush.
